// File: rtl/rr_arb_mux_if.sv
// Bundle of the N-channel requester side and the single consumer side of rr_arb_mux.
// in_lock exists only when RR_ARB_MUX_LOCK_EN is defined.
interface rr_arb_mux_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned SEL_BITS = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [NUM_CH-1:0]       in_lock;
`endif
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_BITS-1:0]     out_sel;

    // Arbiter side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
        input  in_lock,
`endif
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sel
    );

    // Requesters plus consumer side.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
        output in_lock,
`endif
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// Round-robin N-channel valid/ready mux with a one-deep registered output stage.
// Optional burst lock on the last winner: define RR_ARB_MUX_LOCK_EN.
module rr_arb_mux #(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned NUM_CH   = 4,
    localparam int unsigned SEL_BITS = $clog2(NUM_CH)
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_mux_if.slave  bus
);

    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SEL_BITS-1:0] r_out_sel;
    logic [SEL_BITS-1:0] r_last_grant;
`ifdef RR_ARB_MUX_LOCK_EN
    logic                r_lock;
    logic                w_hold;
`endif

    logic                w_load;
    logic                w_any;
    logic                w_xfer;
    logic [SEL_BITS-1:0] w_win;
    logic [WIDTH-1:0]    w_win_data;
    logic [NUM_CH-1:0]   w_ready;
    int unsigned         w_dist;
    int unsigned         w_best;

    // Winner = valid channel with the smallest distance after last_grant.
    always_comb begin
        w_load = ~r_out_valid | bus.out_ready;
        w_any  = |bus.in_valid;
        w_win  = '0;
        w_best = NUM_CH;
        w_dist = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_dist = (i + NUM_CH - 1 - 32'(r_last_grant)) % NUM_CH;
            if (bus.in_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = SEL_BITS'(i);
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        w_hold = bus.in_valid[r_last_grant] & bus.in_lock[r_last_grant];
        if (r_lock && w_hold) begin
            w_win = r_last_grant;
        end
`endif
        w_xfer = w_load & w_any;
    end

    // One-hot accept and winner payload select.
    always_comb begin
        w_ready    = '0;
        w_win_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (SEL_BITS'(i) == w_win) begin
                w_ready[i] = w_xfer;
                w_win_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_sel    <= '0;
            r_last_grant <= SEL_BITS'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_out_data   <= w_win_data;
                r_out_sel    <= w_win;
                r_out_valid  <= 1'b1;
                r_last_grant <= w_win;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    // Lock is armed by a locked transfer and dropped once the holder lets go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (w_xfer) begin
            r_lock <= bus.in_lock[w_win];
        end else if (!w_hold) begin
            r_lock <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: literal checkpoints plus a per-cycle reference model.
module tb_rr_arb_mux;
    localparam int unsigned W  = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned SB = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rr_arb_mux_if #(.WIDTH(W), .NUM_CH(N)) bus ();

    rr_arb_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: the registered output stage and the round-robin pointer.
    logic [W-1:0] m_data;
    logic         m_valid;
    int           m_sel;
    int           m_last;
    logic         m_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ch_data(input int c);
        return bus.in_data[c*W +: W];
    endfunction

    function automatic logic lock_bit(input int c);
`ifdef RR_ARB_MUX_LOCK_EN
        return bus.in_lock[c];
`else
        return 1'b0;
`endif
    endfunction

    // Winner from the rules: a held lock wins, else first valid after m_last.
    function automatic int model_win();
        if (m_lock && bus.in_valid[m_last] && lock_bit(m_last)) return m_last;
        for (int k = 1; k <= N; k++) begin
            if (bus.in_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data = '0; m_valid = 1'b0; m_sel = 0; m_last = N - 1; m_lock = 1'b0;
        end else begin
            int w;
            w = model_win();
            if (!m_valid || bus.out_ready) begin
                if (w >= 0) begin
                    m_data = ch_data(w); m_sel = w; m_valid = 1'b1;
                    m_lock = lock_bit(w); m_last = w;
                end else begin
                    m_valid = 1'b0;
                    m_lock = 1'b0;
                end
            end else if (!(bus.in_valid[m_last] && lock_bit(m_last))) begin
                m_lock = 1'b0;
            end
        end
    end

    // Every cycle, away from the active edge: outputs and accepts against the model.
    always @(negedge clk) begin
        int          w;
        logic [N-1:0] er;
        w  = model_win();
        er = '0;
        if ((!m_valid || bus.out_ready) && w >= 0) er[w] = 1'b1;
        chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("m_in_ready",  32'(bus.in_ready),  32'(er));
        if (m_valid) begin
            chk("m_out_data", 32'(bus.out_data), 32'(m_data));
            chk("m_out_sel",  32'(bus.out_sel),  32'(m_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [W-1:0] v);
        bus.in_data[c*W +: W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    logic [N-1:0] vec_v [16] = '{4'b0001, 4'b1001, 4'b1001, 4'b0000, 4'b0110, 4'b1111, 4'b1010, 4'b0100,
                                 4'b1111, 4'b0011, 4'b0000, 4'b1000, 4'b1100, 4'b0101, 4'b1111, 4'b0010};
    logic         vec_r [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        bus.in_lock   = '0;
`endif
        // Reset then idle, then a single request on channel 2.
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        set_data(2, 16'h1234);
        bus.in_valid = 4'b0100;
        #1 chk("first_in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        bus.in_valid = '0;
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_data",  32'(bus.out_data),  32'h1234);
        chk("first_sel",   32'(bus.out_sel),   32'd2);
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_sel",   32'(bus.out_sel),   32'd2);

        // Fairness from a fresh pointer: 0,1,2,3 repeating.
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 16'(16'hA0 + i));
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fair_sel",  32'(bus.out_sel),  32'(i % 4));
            chk("fair_data", 32'(bus.out_data), 32'(16'hA0 + (i % 4)));
        end

        // Backpressure while holding 0xA1.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_data",     32'(bus.out_data), 32'hA1);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_sel", 32'(bus.out_sel), 32'd2);
        tick();
        chk("pre_wrap_sel", 32'(bus.out_sel), 32'd3);

        // Wrap and skip.
        bus.in_valid = 4'b0010;
        tick();
        chk("wrap_sel",  32'(bus.out_sel),  32'd1);
        chk("wrap_data", 32'(bus.out_data), 32'hA1);
        bus.in_valid = 4'b0011;
        tick();
        chk("skip_sel", 32'(bus.out_sel), 32'd0);

        // Asynchronous reset while a beat is pending.
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_sel", 32'(bus.out_sel), 32'd0);

`ifdef RR_ARB_MUX_LOCK_EN
        // Channel 1 locks for three beats, then round-robin resumes after it.
        bus.in_valid = 4'b0111;
        bus.in_lock  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lock_sel", 32'(bus.out_sel), 32'd1);
        end
        bus.in_lock = '0;
        tick();
        chk("unlock_sel_a", 32'(bus.out_sel), 32'd2);
        tick();
        chk("unlock_sel_b", 32'(bus.out_sel), 32'd0);
`endif

        // Mixed valid/ready table, checked by the reference model.
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < N; c++) set_data(c, 16'($urandom_range(0, 16'hFFFF)));
            bus.in_valid  = vec_v[i];
            bus.out_ready = vec_r[i];
            tick();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel successor to the two-input address/data muxes.
- Selects one of NUM_CH valid/ready source channels by round-robin arbitration and presents the winner through a registered output stage.
- Sits between multiple bus requesters (fetch, load/store, DMA) and a single downstream address or data bus consumer.
- One-cycle latency, full-throughput when the consumer is always ready.

Parameters:
- WIDTH, default DATA_BUS_WIDTH (from params.v): payload width in bits; instantiate with ADDRESS_BUS_WIDTH for address paths.
- NUM_CH, default 4: number of input channels, legal range 2..16.
- SEL_BITS, default $clog2(NUM_CH): width of the channel index. Derived; never overridden.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, NUM_CH*WIDTH: channel i payload at bits [i*WIDTH +: WIDTH].
- in_valid, input, NUM_CH: per-channel request and valid.
- in_ready, output, NUM_CH: per-channel accept; at most one bit is high per cycle.
- out_data, output, WIDTH: registered payload of the accepted beat.
- out_valid, output, 1: out_data holds an unconsumed beat.
- out_ready, input, 1: downstream accept.
- out_sel, output, SEL_BITS: index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 has first priority.
  - in_ready follows combinationally, so it reads 0 while no channel is valid.
- load = ~out_valid | out_ready. The output register may take a new beat this cycle.
- Arbitration (combinational):
  - Search channels last_grant+1, last_grant+2, ... wrapping modulo NUM_CH.
  - The first channel with in_valid set wins.
  - in_ready[win] = load & any(in_valid). All other in_ready bits are 0.
  - in_ready never depends on in_data.
- Transfer on channel i happens when in_valid[i] & in_ready[i]. At the next edge:
  - out_data <= channel i payload.
  - out_sel <= i.
  - out_valid <= 1.
  - last_grant <= i.
- If load=1 and no channel is valid:
  - out_valid <= 0.
  - out_data and out_sel hold their previous values.
  - last_grant holds.
- If load=0 (out_valid=1, out_ready=0):
  - out_data and out_sel are frozen.
  - All in_ready bits are 0 and last_grant holds.
- Simultaneous drain and fill (out_valid=1, out_ready=1, a channel valid): the new beat replaces the old one in the same edge. There is no bubble.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NUM_CH-1,0. Each channel gets exactly one beat per NUM_CH cycles.
- Wrap-around: when last_grant=NUM_CH-1, the search starts at channel 0.
- Reset mid-transfer: a pending output beat is discarded, out_valid drops immediately, and the pointer returns to NUM_CH-1.
- Source rule: a source must hold in_valid and in_data stable until its in_ready is sampled high. The block does not check this.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- When defined:
  - Adds input port in_lock, width NUM_CH.
  - If the channel that won the last transfer still has in_valid and in_lock set, it wins again, bypassing round-robin. This supports multi-beat bursts and atomic read-modify-write.
  - The lock releases on the first cycle the holder deasserts in_lock or in_valid. Round-robin then resumes from that channel's index.
  - Reset clears the lock state.
- When undefined: there is no in_lock port, and pure round-robin arbitration applies.

Test Plan:
- Reset then idle: assert rst for 3 cycles, no valids -> out_valid=0, out_sel=0, in_ready=4'b0000. Then raise in_valid[2] with data 0x1234 -> next cycle out_valid=1, out_data=0x1234, out_sel=2.
- Fairness: NUM_CH=4, all in_valid=1 with data 0xA0..0xA3, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 0xA0,0xA1,0xA2,0xA3 repeating.
- Backpressure: out_valid=1 with out_data=0xA1, hold out_ready=0 for 5 cycles -> in_ready=0, out_data stays 0xA1. Release out_ready -> next grant is channel 2.
- Wrap and skip: last_grant=3, only in_valid[1]=1 -> channel 1 granted. Next cycle, in_valid[0] and in_valid[1] both set -> channel 0 granted.
- Mid-operation reset: assert rst asynchronously while out_valid=1 -> out_valid=0 before the next clock edge. After release with all channels valid, the first grant is channel 0.
- Lock (RR_ARB_MUX_LOCK_EN): channel 1 holds in_lock=1 for 3 beats while channels 0 and 2 are valid -> out_sel=1,1,1. Drop the lock -> subsequent grants are 2, then 0.
